// File: rtl/video_sequencer_if.sv
// ---------------------------------------------------------------------------
// video_sequencer_if
// Bundle between the video timing sequencer and the PPU logic it drives.
//   I_clk_rise      : dot enable, all sequencer state advances only when high
//   I_render_enable : PPUMASK background OR sprite enable
//   O_hcount        : current dot
//   O_vcount        : current line
//   O_odd_frame     : frame parity, 1 = odd frame
//   O_frame_start   : one-dot pulse at (0,0)
//   O_ready         : warm-up complete, register writes are honoured
//   O_control       : 16-bit fetch / scroll / status strobe word
// master = the sequencer, slave = the downstream consumer.
// ---------------------------------------------------------------------------
interface video_sequencer_if #(
  parameter int P_width = 16
);
  logic               I_clk_rise;
  logic               I_render_enable;
  logic [P_width-1:0] O_hcount;
  logic [P_width-1:0] O_vcount;
  logic               O_odd_frame;
  logic               O_frame_start;
  logic               O_ready;
  logic [15:0]        O_control;

  modport master (
    input  I_clk_rise,
    input  I_render_enable,
    output O_hcount,
    output O_vcount,
    output O_odd_frame,
    output O_frame_start,
    output O_ready,
    output O_control
  );

  modport slave (
    output I_clk_rise,
    output I_render_enable,
    input  O_hcount,
    input  O_vcount,
    input  O_odd_frame,
    input  O_frame_start,
    input  O_ready,
    input  O_control
  );
endinterface

// File: rtl/video_sequencer.sv
// ---------------------------------------------------------------------------
// video_sequencer
// Dot/line counters, frame parity with odd-frame dot skip, warm-up tracking
// and a registered 16-bit control word aligned with the counters.
// Ports:
//   I_vid_clock : video clock
//   I_reset_n   : asynchronous active-low reset
//   bus         : video_sequencer_if.master (dot enable, render enable,
//                 counters, parity, frame pulse, ready, control word)
// Control word:
//   [7:0] fetch phase one-hot of h[2:0]   [8]  vblank_set   [9]  vblank_clr
//   [10]  is_rendering   [11] incr_hori_v  [12] incr_vert_v  [13] hori_v_eq_t
//   [14]  vert_v_eq_t    [15] sprite_fetch
// ---------------------------------------------------------------------------
module video_sequencer #(
  parameter int P_width          = 16,
  parameter int P_h_total        = 341,
  parameter int P_v_total        = 262,
  parameter int P_visible_lines  = 240,
  parameter int P_vblank_line    = 241,
  parameter int P_prerender_line = 261,
  parameter int P_vblank_col     = 1,
  parameter int P_odd_skip       = 1
) (
  input  logic                I_vid_clock,
  input  logic                I_reset_n,
  video_sequencer_if.master   bus
);

  localparam logic [P_width-1:0] L_h_last   = P_width'(P_h_total - 1);
  localparam logic [P_width-1:0] L_h_skip   = P_width'(P_h_total - 2);
  localparam logic [P_width-1:0] L_v_last   = P_width'(P_v_total - 1);
  localparam logic [P_width-1:0] L_visible  = P_width'(P_visible_lines);
  localparam logic [P_width-1:0] L_vblank   = P_width'(P_vblank_line);
  localparam logic [P_width-1:0] L_prerend  = P_width'(P_prerender_line);
  localparam logic [P_width-1:0] L_vcol     = P_width'(P_vblank_col);
  localparam logic [P_width-1:0] L_one      = P_width'(1);
  localparam logic [P_width-1:0] L_h256     = P_width'(256);
  localparam logic [P_width-1:0] L_h257     = P_width'(257);
  localparam logic [P_width-1:0] L_h280     = P_width'(280);
  localparam logic [P_width-1:0] L_h304     = P_width'(304);
  localparam logic [P_width-1:0] L_h320     = P_width'(320);

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [P_width-1:0] r_hcount;
  logic [P_width-1:0] r_vcount;
  logic               r_odd_frame;
  logic               r_frame_start;
  logic [15:0]        r_control;

  logic [P_width-1:0] w_h_next;
  logic [P_width-1:0] w_v_next;
  logic               w_odd_next;
  logic               w_skip;
  logic               w_rendering;
  logic               w_fetch;
  logic               w_sprite;
  logic [7:0]         w_phase;
  logic [15:0]        w_control_next;

  // Next position. The skip jumps straight from (prerender, h_total-2) to
  // (0,0) and counts as the frame wrap, so parity toggles there too.
  always_comb begin
    w_h_next   = r_hcount;
    w_v_next   = r_vcount;
    w_odd_next = r_odd_frame;
    w_skip     = (P_odd_skip != 0) && r_odd_frame && bus.I_render_enable &&
                 (r_vcount == L_prerend) && (r_hcount == L_h_skip);
    if (w_skip) begin
      w_h_next   = '0;
      w_v_next   = '0;
      w_odd_next = ~r_odd_frame;
    end else if (r_hcount == L_h_last) begin
      w_h_next = '0;
      if (r_vcount == L_v_last) begin
        w_v_next   = '0;
        w_odd_next = ~r_odd_frame;
      end else begin
        w_v_next = r_vcount + L_one;
      end
    end else begin
      w_h_next = r_hcount + L_one;
    end
  end

  // Decode runs on the position being entered so the registered word lines
  // up with the counters it is registered alongside.
  assign w_rendering = (w_v_next < L_visible) || (w_v_next == L_prerend);
  assign w_fetch     = w_rendering && (w_h_next >= L_one) && bus.I_render_enable;
  assign w_sprite    = (w_h_next >= L_h257) && (w_h_next <= L_h320);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_phase
      assign w_phase[gi] = w_fetch && (w_h_next[2:0] == 3'(gi));
    end
  endgenerate

  always_comb begin
    w_control_next        = 16'h0000;
    w_control_next[7:0]   = w_phase;
    w_control_next[8]     = (w_v_next == L_vblank)  && (w_h_next == L_vcol);
    w_control_next[9]     = (w_v_next == L_prerend) && (w_h_next == L_vcol);
    w_control_next[10]    = w_rendering;
    w_control_next[11]    = w_fetch && (w_h_next[2:0] == 3'd0) && !w_sprite;
    w_control_next[12]    = w_fetch && (w_h_next == L_h256);
    w_control_next[13]    = w_fetch && (w_h_next == L_h257);
    w_control_next[14]    = w_fetch && (w_v_next == L_prerend) &&
                            (w_h_next >= L_h280) && (w_h_next <= L_h304);
    w_control_next[15]    = w_fetch && w_sprite;
  end

  // Warm-up FSM: leaves WARMUP on the rise that enters (prerender, 0).
  always_ff @(posedge I_vid_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state <= ST_WARMUP;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WARMUP: begin
        if (bus.I_clk_rise && (w_v_next == L_prerend) && (w_h_next == '0)) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_WARMUP;
    endcase
  end

  always_ff @(posedge I_vid_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_odd_frame   <= 1'b0;
      r_frame_start <= 1'b0;
      r_control     <= 16'h0000;
    end else if (bus.I_clk_rise) begin
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_odd_frame   <= w_odd_next;
      r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
      r_control     <= w_control_next;
    end
  end

  assign bus.O_hcount      = r_hcount;
  assign bus.O_vcount      = r_vcount;
  assign bus.O_odd_frame   = r_odd_frame;
  assign bus.O_frame_start = r_frame_start;
  assign bus.O_ready       = (r_state == ST_RUN);
  assign bus.O_control     = r_control;

endmodule
